// File: rtl/pwm_modulator.sv
// Turns Q1.15 u into a dead-time-protected complementary gate pair with a per-period sample trigger.
// Outputs registered (1 cycle); no backpressure: u_valid is always accepted, and an unused overwrite pulses upd_miss.
module pwm_modulator #(
    parameter int W     = 16,
    parameter int CNT_W = 12,
    parameter int DT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [W-1:0]     u_in,
    input  logic             u_valid,
    input  logic [CNT_W-1:0] period,
    input  logic [DT_W-1:0]  dead_time,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             sample_trig,
    output logic [CNT_W-1:0] duty_cur,
    output logic             upd_miss
);

    typedef enum logic [1:0] {ST_OFF, ST_DT, ST_HI, ST_LO} state_t;

    state_t           state, state_d;
    logic             tgt, tgt_d;
    logic [DT_W-1:0]  dt_cnt, dt_cnt_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] period_sh, period_act, duty_act, duty_map, duty_full;
    logic [W-1:0]     u_pend;
    logic             pend, pend_d, running, wrap, raw;
    logic [CNT_W:0]   period_p1;
    logic [W+CNT_W-1:0] prod;
    logic [W-2:0]     frac_unused;
    logic             top_unused;

    assign running = enable && (state != ST_OFF);
    assign wrap    = running && (cnt == period_act);
    assign cnt_d   = (!running || wrap) ? '0 : cnt + CNT_W'(1);
    assign raw     = cnt < duty_act;

    // Product of magnitude and (period+1) never reaches (period+1)<<15, so duty stays <= period.
    assign period_p1 = {1'b0, period_sh} + (CNT_W+1)'(1);
    assign prod      = (W+CNT_W)'(u_pend[W-2:0]) * (W+CNT_W)'(period_p1);
    assign {top_unused, duty_full, frac_unused} = prod;
    assign duty_map  = u_pend[W-1] ? '0 : duty_full;

    assign pend_d   = u_valid ? 1'b1 : (wrap ? 1'b0 : pend);
    assign duty_cur = duty_act;

    always_comb begin
        state_d  = state;
        tgt_d    = tgt;
        dt_cnt_d = dt_cnt;
        if (!enable) begin
            state_d  = ST_OFF;
            dt_cnt_d = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_d  = ST_DT;
                    tgt_d    = raw;
                    dt_cnt_d = '0;
                end
                ST_DT: begin
                    // A raw change mid dead-time restarts it so short pulses never reach a gate.
                    if (raw != tgt) begin
                        tgt_d    = raw;
                        dt_cnt_d = '0;
                    end else if (dt_cnt == dead_time) begin
                        state_d  = tgt ? ST_HI : ST_LO;
                        dt_cnt_d = '0;
                    end else begin
                        dt_cnt_d = dt_cnt + DT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!raw) begin
                        state_d  = ST_DT;
                        tgt_d    = 1'b0;
                        dt_cnt_d = '0;
                    end
                end
                ST_LO: begin
                    if (raw) begin
                        state_d  = ST_DT;
                        tgt_d    = 1'b1;
                        dt_cnt_d = '0;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_OFF;
            tgt    <= 1'b0;
            dt_cnt <= '0;
        end else begin
            state  <= state_d;
            tgt    <= tgt_d;
            dt_cnt <= dt_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_sh   <= '0;
            period_act  <= '0;
            duty_act    <= '0;
            u_pend      <= '0;
            pend        <= 1'b0;
            upd_miss    <= 1'b0;
            pwm_hi      <= 1'b0;
            pwm_lo      <= 1'b0;
            sample_trig <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            period_sh <= period;
            if (wrap) begin
                period_act <= period_sh;
                if (pend) duty_act <= duty_map;
            end
            if (u_valid) u_pend <= u_in;
            pend        <= pend_d;
            // A pending value consumed in this same cycle was used, so it is not a miss.
            upd_miss    <= u_valid && pend && !wrap;
            pwm_hi      <= (state_d == ST_HI);
            pwm_lo      <= (state_d == ST_LO);
            sample_trig <= (state_d != ST_OFF) && (cnt_d == '0);
        end
    end

endmodule
